display_scan_controller: RTL and testbench



---
 rtl/display_scan_controller_if.sv | 11 +
 rtl/display_scan_controller.sv | 118 +++++++++++
 tb/tb_display_scan_controller.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/display_scan_controller_if.sv
// Load handshake bundle for display_scan_controller: valid/ready plus packed BCD nibbles.
interface display_scan_controller_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    LoadValid;
  logic [4*NUM_DIGITS-1:0] LoadData;
  logic                    LoadReady;

  modport master (output LoadValid, output LoadData, input LoadReady);
  modport slave  (input LoadValid, input LoadData, output LoadReady);
endinterface

// File: rtl/display_scan_controller.sv
// Multiplexes one shared BCD-to-7-segment decoder across NUM_DIGITS common-anode digits,
// with dead-time between digits and frame-boundary commit of new values.
// Optional: DISPLAY_LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module display_scan_controller #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int DEAD_CYCLES = 16
) (
  input  logic                    Clock,
  input  logic                    Resetn,
  display_scan_controller_if.slave load,
  output logic [0:3]              DigitCode,
  output logic [NUM_DIGITS-1:0]   DigitSel
);

  localparam int MAX_CYC  = (REFRESH_DIV > DEAD_CYCLES) ? REFRESH_DIV : DEAD_CYCLES;
  localparam int CNT_W    = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int IDX_W    = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] ON_LAST   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic {
    DEAD,
    ON
  } state_t;

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx;
  logic [4*NUM_DIGITS-1:0] shadow;
  logic [4*NUM_DIGITS-1:0] pend_buf;
  logic                    pending;

  logic [3:0]              nib [NUM_DIGITS];
  logic [3:0]              code_next;
  logic                    frame_end;

  always_comb begin
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      nib[i] = shadow[4*i +: 4];
    end
  end

`ifdef DISPLAY_LEADING_ZERO_BLANK_EN
  // upper_zero[i]: nibbles NUM_DIGITS-1 down to i are all zero
  logic [NUM_DIGITS-1:0] upper_zero;

  always_comb begin
    upper_zero = '0;
    upper_zero[NUM_DIGITS-1] = (nib[NUM_DIGITS-1] == 4'h0);
    for (int unsigned j = 1; j < NUM_DIGITS; j++) begin
      upper_zero[NUM_DIGITS-1-j] = upper_zero[NUM_DIGITS-j] && (nib[NUM_DIGITS-1-j] == 4'h0);
    end
    code_next = nib[idx];
    if ((idx != '0) && upper_zero[idx]) begin
      code_next = 4'hF;
    end
  end
`else
  always_comb begin
    code_next = nib[idx];
  end
`endif

  assign frame_end = (state == ON) && (cnt == ON_LAST) && (idx == IDX_LAST);

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state          <= DEAD;
      cnt            <= '0;
      idx            <= '0;
      DigitCode      <= '1;
      DigitSel       <= '1;
      shadow         <= '1;
      pend_buf       <= '0;
      pending        <= 1'b0;
      load.LoadReady <= 1'b1;
    end else begin
      case (state)
        DEAD: begin
          if (cnt == DEAD_LAST) begin
            state     <= ON;
            cnt       <= '0;
            DigitSel  <= ~(NUM_DIGITS'(1) << idx);
            DigitCode <= code_next;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ON: begin
          if (cnt == ON_LAST) begin
            state     <= DEAD;
            cnt       <= '0;
            DigitSel  <= '1;
            DigitCode <= '1;
            idx       <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= DEAD;
      endcase

      // LoadReady is high only while nothing is pending, so commit and capture never coincide
      if (frame_end && pending) begin
        shadow         <= pend_buf;
        pending        <= 1'b0;
        load.LoadReady <= 1'b1;
      end else if (load.LoadValid && load.LoadReady) begin
        pend_buf       <= load.LoadData;
        pending        <= 1'b1;
        load.LoadReady <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_display_scan_controller.sv
// Self-checking bench for display_scan_controller (4 digits, 4-cycle ON, 2-cycle dead time).
module tb_display_scan_controller;

  localparam int ND    = 4;
  localparam int RD    = 4;
  localparam int DC    = 2;
  localparam int SLOT  = RD + DC;
  localparam int FRAME = ND * SLOT;

  logic          Clock;
  logic          Resetn;
  logic [0:3]    DigitCode;
  logic [ND-1:0] DigitSel;

  display_scan_controller_if #(.NUM_DIGITS(ND)) lif ();

  display_scan_controller #(
    .NUM_DIGITS (ND),
    .REFRESH_DIV(RD),
    .DEAD_CYCLES(DC)
  ) dut (
    .Clock    (Clock),
    .Resetn   (Resetn),
    .load     (lif),
    .DigitCode(DigitCode),
    .DigitSel (DigitSel)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int t        = 0;

  // Reference model: time within frame determines the lit digit; data flows pending -> shadow
  logic [15:0] m_shadow;
  logic [15:0] m_buf;
  logic        m_pend;
  logic        m_ready;

  typedef struct {
    logic [15:0] data;
    logic [15:0] codes;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, t);
    end
  endtask

  function automatic logic [3:0] exp_code(input int tt);
    int ph = tt % SLOT;
    int dg = (tt / SLOT) % ND;
    if (ph < DC) return 4'hF;
`ifdef DISPLAY_LEADING_ZERO_BLANK_EN
    if (dg > 0) begin
      bit z = 1'b1;
      for (int k = dg; k < ND; k++) if (m_shadow[4*k +: 4] != 4'h0) z = 1'b0;
      if (z) return 4'hF;
    end
`endif
    return m_shadow[4*dg +: 4];
  endfunction

  function automatic logic [ND-1:0] exp_sel(input int tt);
    int ph = tt % SLOT;
    int dg = (tt / SLOT) % ND;
    logic [ND-1:0] s = '1;
    if (ph >= DC) s[dg] = 1'b0;
    return s;
  endfunction

  task automatic step(input logic v, input logic [15:0] d);
    chk("DigitSel", int'(DigitSel), int'(exp_sel(t)));
    chk("DigitCode", int'(DigitCode), int'(exp_code(t)));
    chk("LoadReady", int'(lif.LoadReady), int'(m_ready));
    lif.LoadValid = v;
    lif.LoadData  = d;
    @(posedge Clock);
    #1;
    if (((t + 1) % FRAME == 0) && m_pend) begin
      m_shadow = m_buf;
      m_pend   = 1'b0;
      m_ready  = 1'b1;
    end else if (v && m_ready) begin
      m_buf   = d;
      m_pend  = 1'b1;
      m_ready = 1'b0;
    end
    t++;
  endtask

  task automatic do_reset();
    Resetn = 1'b0;
    lif.LoadValid = 1'b0;
    #1;
    chk("rst_DigitSel", int'(DigitSel), 'hF);
    chk("rst_DigitCode", int'(DigitCode), 'hF);
    chk("rst_LoadReady", int'(lif.LoadReady), 1);
    @(posedge Clock);
    #1;
    Resetn   = 1'b1;
    m_shadow = 16'hFFFF;
    m_buf    = '0;
    m_pend   = 1'b0;
    m_ready  = 1'b1;
    t        = 0;
  endtask

  initial begin
    logic [15:0] d3;
    logic [15:0] d24;
    logic [15:0] cw;
    Resetn        = 1'b0;
    lif.LoadValid = 1'b0;
    lif.LoadData  = '0;

    vecs[0] = '{16'h1234, 16'h1234};
    vecs[1] = '{16'h9AF0, 16'h9AF0};
`ifdef DISPLAY_LEADING_ZERO_BLANK_EN
    vecs[2] = '{16'h0070, 16'hFF70};
    vecs[3] = '{16'h0000, 16'hFFF0};
`else
    vecs[2] = '{16'h0070, 16'h0070};
    vecs[3] = '{16'h0000, 16'h0000};
`endif

    #12;
    // Table vectors: load at cycle 3, verify the frame after commit
    for (int i = 0; i < 4; i++) begin
      do_reset();
      cw = vecs[i].codes;
      while (t < 2 * FRAME) begin
        if (t == 4) chk("ready_drop", int'(lif.LoadReady), 0);
        if (t == FRAME) chk("ready_back", int'(lif.LoadReady), 1);
        if (t >= FRAME && (t % SLOT) == DC) begin
          chk("tbl_code", int'(DigitCode), int'(cw[4*((t / SLOT) % ND) +: 4]));
          chk("tbl_sel", int'(DigitSel), int'(exp_sel(t)));
        end
        step(t == 3, (t == 3) ? vecs[i].data : 16'h0);
      end
    end

    // LoadValid held high with changing data: only the cycle-3 value is taken, next at cycle 24
    do_reset();
    d3  = '0;
    d24 = '0;
    while (t < 2 * FRAME + 8) begin
      logic [15:0] d;
      d = 16'($urandom);
      if (t == 3) d3 = d;
      if (t == FRAME) d24 = d;
      if (t == FRAME) chk("held_ready_hi", int'(lif.LoadReady), 1);
      if (t == FRAME + 1) chk("held_ready_lo", int'(lif.LoadReady), 0);
      if (t == FRAME + DC) chk("held_first", int'(DigitCode), int'(d3[3:0]));
      if (t == 2 * FRAME + DC) chk("held_second", int'(DigitCode), int'(d24[3:0]));
      step(t >= 3 && t <= FRAME + 6, d);
    end

    // Reset during digit 2 ON with a pending load: pending data must never appear
    do_reset();
    while (t < 2 * SLOT + DC + 1) step(t == 3, 16'h5678);
    do_reset();
    while (t < FRAME + SLOT) begin
      if (t == FRAME + DC) chk("midrst_code", int'(DigitCode), 'hF);
      step(1'b0, 16'h0);
    end

    // Random traffic against the model
    do_reset();
    for (int n = 0; n < 400; n++) begin
      step(($urandom % 4) == 0, 16'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
